// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle single-port RAM between fetch (IF) and load/store (MEM),
// MEM first, and drives the pipeline stalls while an access is pending.
module mem_port_arbiter #(
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   input  logic              i_if_abort,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_ready,
   input  logic              i_mem_read,
   input  logic              i_mem_write,
   input  logic [ADDR_W-1:0] i_mem_addr,
   input  logic [DATA_W-1:0] i_mem_wdata,
   output logic [DATA_W-1:0] o_mem_rdata,
   output logic              o_mem_ready,
   output logic              o_ram_en,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_if_stall,
   output logic              o_mem_stall
);
   typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;
   localparam int CW = $clog2(MEM_LATENCY + 1);

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_mem_rdata;

   logic w_busy, w_done, w_d_done, w_i_done, w_abort, w_arb, w_mreq, w_dreq, w_ireq;

   assign w_busy   = r_state != IDLE;
   assign w_done   = w_busy && r_cnt == '0;
   assign w_d_done = r_state == D_ACC && w_done;
   assign w_i_done = r_state == I_ACC && w_done;
   assign w_abort  = r_state == I_ACC && i_if_abort;
   assign w_arb    = !w_busy || w_done || w_abort;
   assign w_mreq   = i_mem_read || i_mem_write;
   // Completing or aborted requesters sit out this arbitration round.
   assign w_dreq   = w_mreq && !w_d_done;
   assign w_ireq   = i_if_req && !w_i_done && !w_abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_we        <= 1'b0;
         r_if_rdata  <= '0;
         r_mem_rdata <= '0;
      end else begin
         if (w_arb) begin
            if (w_dreq) begin
               r_state <= D_ACC;
               r_addr  <= i_mem_addr;
               r_wdata <= i_mem_wdata;
               r_we    <= i_mem_write;
               r_cnt   <= CW'(MEM_LATENCY - 1);
            end else if (w_ireq) begin
               r_state <= I_ACC;
               r_addr  <= i_if_addr;
               r_we    <= 1'b0;
               r_cnt   <= CW'(MEM_LATENCY - 1);
            end else begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         end else begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (w_d_done && !r_we) r_mem_rdata <= i_ram_rdata;
         if (w_i_done) r_if_rdata <= i_ram_rdata;
      end
   end

   assign o_ram_en    = w_busy;
   assign o_ram_we    = w_busy && r_we;
   assign o_ram_addr  = w_busy ? r_addr : '0;
   assign o_ram_wdata = w_busy ? r_wdata : '0;
   assign o_mem_ready = w_d_done;
   assign o_if_ready  = w_i_done;
   assign o_mem_rdata = (w_d_done && !r_we) ? i_ram_rdata : r_mem_rdata;
   assign o_if_rdata  = w_i_done ? i_ram_rdata : r_if_rdata;
   assign o_mem_stall = w_mreq && !w_d_done;
   assign o_if_stall  = o_mem_stall || (i_if_req && !w_i_done);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; a MEM_LATENCY=2 DUT is fully checked, a MEM_LATENCY=1
// DUT on the same inputs is checked for single-cycle fetch latency.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        if_req, if_abort, mem_read, mem_write;
   logic [31:0] if_addr, mem_addr, mem_wdata;

   logic [31:0] a_if_rdata, a_mem_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
   logic        a_if_ready, a_mem_ready, a_ram_en, a_ram_we, a_if_stall, a_mem_stall;
   logic [31:0] b_if_rdata, b_mem_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
   logic        b_if_ready, b_mem_ready, b_ram_en, b_ram_we, b_if_stall, b_mem_stall;

   function automatic logic [31:0] ram_f(input logic [31:0] a);
      return (a == 32'h40) ? 32'h2408_0005 : {a[15:0], ~a[15:0]};
   endfunction

   assign a_ram_rdata = ram_f(a_ram_addr);
   assign b_ram_rdata = ram_f(b_ram_addr);

   mem_port_arbiter #(.MEM_LATENCY(2)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .i_if_abort(if_abort),
      .o_if_rdata(a_if_rdata), .o_if_ready(a_if_ready),
      .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
      .o_mem_rdata(a_mem_rdata), .o_mem_ready(a_mem_ready),
      .o_ram_en(a_ram_en), .o_ram_we(a_ram_we), .o_ram_addr(a_ram_addr), .o_ram_wdata(a_ram_wdata),
      .i_ram_rdata(a_ram_rdata), .o_if_stall(a_if_stall), .o_mem_stall(a_mem_stall));

   mem_port_arbiter #(.MEM_LATENCY(1)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .i_if_abort(if_abort),
      .o_if_rdata(b_if_rdata), .o_if_ready(b_if_ready),
      .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
      .o_mem_rdata(b_mem_rdata), .o_mem_ready(b_mem_ready),
      .o_ram_en(b_ram_en), .o_ram_we(b_ram_we), .o_ram_addr(b_ram_addr), .o_ram_wdata(b_ram_wdata),
      .i_ram_rdata(b_ram_rdata), .o_if_stall(b_if_stall), .o_mem_stall(b_mem_stall));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [31:0] data; int cyc;} exp_t;
   exp_t q_if[$], q_mem[$], e_if, e_mem;
   logic [31:0] prev;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Scoreboard: every ready pulse must match the oldest expected completion.
   always @(negedge clk) if (rst_n) begin
      if (a_if_ready) begin
         if (q_if.size() == 0) check("if_unexpected_ready", 64'(a_if_ready), 0);
         else begin
            e_if = q_if.pop_front();
            check("if_rdata", 64'(a_if_rdata), 64'(e_if.data));
            check("if_ready_cycle", 64'(cyc), 64'(e_if.cyc));
         end
      end
      if (a_mem_ready) begin
         if (q_mem.size() == 0) check("mem_unexpected_ready", 64'(a_mem_ready), 0);
         else begin
            e_mem = q_mem.pop_front();
            check("mem_rdata", 64'(a_mem_rdata), 64'(e_mem.data));
            check("mem_ready_cycle", 64'(cyc), 64'(e_mem.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic wait_rdy(input bit is_if);
      int n = 0;
      @(negedge clk);
      while (!(is_if ? a_if_ready : a_mem_ready) && n < 20) begin
         n++;
         @(negedge clk);
      end
      check(is_if ? "if_ready_wait" : "mem_ready_wait", 64'(is_if ? a_if_ready : a_mem_ready), 1);
   endtask

   initial begin
      {if_req, if_abort, mem_read, mem_write} = '0;
      {if_addr, mem_addr, mem_wdata} = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ram_en", 64'(a_ram_en), 0);
      check("rst_ram_addr", 64'(a_ram_addr), 0);
      check("rst_if_ready", 64'(a_if_ready), 0);
      check("rst_mem_ready", 64'(a_mem_ready), 0);
      check("rst_if_rdata", 64'(a_if_rdata), 0);
      check("rst_mem_rdata", 64'(a_mem_rdata), 0);
      rst_n = 1'b1;
      tick();
      // single fetch
      if_req = 1; if_addr = 32'h40;
      q_if.push_back('{ram_f(32'h40), cyc + 2});
      sample();
      check("t1_ram_en_c0", 64'(a_ram_en), 0);
      check("t1_if_stall_c0", 64'(a_if_stall), 1);
      tick(); sample();
      check("t1_ram_en_c1", 64'(a_ram_en), 1);
      check("t1_ram_addr", 64'(a_ram_addr), 64'h40);
      check("t1_ram_we", 64'(a_ram_we), 0);
      check("t1_if_stall_c1", 64'(a_if_stall), 1);
      tick(); sample();
      check("t1_ram_en_c2", 64'(a_ram_en), 1);
      check("t1_if_stall_done", 64'(a_if_stall), 0);
      tick(); if_req = 0; sample();
      check("t1_ram_en_after", 64'(a_ram_en), 0);
      check("t1_if_rdata_hold", 64'(a_if_rdata), 64'h2408_0005);
      // simultaneous fetch and load: load first, fetch back-to-back
      tick();
      if_req = 1; if_addr = 32'h44; mem_read = 1; mem_addr = 32'h1000;
      q_mem.push_back('{ram_f(32'h1000), cyc + 2});
      q_if.push_back('{ram_f(32'h44), cyc + 4});
      wait_rdy(0);
      check("t2_if_stall", 64'(a_if_stall), 1);
      check("t2_mem_stall", 64'(a_mem_stall), 0);
      tick(); mem_read = 0;
      wait_rdy(1);
      tick(); if_req = 0;
      // store: rdata unchanged
      prev = ram_f(32'h1000);
      mem_write = 1; mem_addr = 32'h1004; mem_wdata = 32'hDEAD_BEEF;
      q_mem.push_back('{prev, cyc + 2});
      sample();
      check("t3_ram_we_c0", 64'(a_ram_we), 0);
      tick(); sample();
      check("t3_ram_we_c1", 64'(a_ram_we), 1);
      check("t3_ram_addr", 64'(a_ram_addr), 64'h1004);
      check("t3_ram_wdata", 64'(a_ram_wdata), 64'hDEAD_BEEF);
      tick(); sample();
      check("t3_ram_we_c2", 64'(a_ram_we), 1);
      tick(); mem_write = 0; sample();
      check("t3_ram_we_after", 64'(a_ram_we), 0);
      check("t3_mem_rdata_hold", 64'(a_mem_rdata), 64'(prev));
      // load raised mid-fetch waits for the fetch
      tick();
      if_req = 1; if_addr = 32'h48;
      q_if.push_back('{ram_f(32'h48), cyc + 2});
      tick();
      mem_read = 1; mem_addr = 32'h1004;
      q_mem.push_back('{ram_f(32'h1004), cyc + 3});
      sample();
      check("t4_mem_stall_wait", 64'(a_mem_stall), 1);
      wait_rdy(1);
      check("t4_mem_stall_ifdone", 64'(a_mem_stall), 1);
      check("t4_ram_addr_fetch", 64'(a_ram_addr), 64'h48);
      tick(); if_req = 0; sample();
      check("t4_ram_addr_load", 64'(a_ram_addr), 64'h1004);
      wait_rdy(0);
      tick(); mem_read = 0;
      // abort in the first fetch cycle, then a fresh fetch with full latency
      tick();
      if_req = 1; if_addr = 32'h4C;
      tick(); if_abort = 1; sample();
      check("t5_ram_en_abort", 64'(a_ram_en), 1);
      check("t5_ram_addr_abort", 64'(a_ram_addr), 64'h4C);
      tick(); if_abort = 0; if_addr = 32'h50;
      q_if.push_back('{ram_f(32'h50), cyc + 2});
      sample();
      check("t5_idle_after_abort", 64'(a_ram_en), 0);
      wait_rdy(1);
      tick(); if_req = 0;
      // reset mid-load
      tick();
      mem_read = 1; mem_addr = 32'h1000;
      tick(); sample();
      check("t6_ram_en_busy", 64'(a_ram_en), 1);
      #1 rst_n = 0; mem_read = 0;
      #1;
      check("t6_rst_ram_en", 64'(a_ram_en), 0);
      check("t6_rst_ram_addr", 64'(a_ram_addr), 0);
      check("t6_rst_ram_wdata", 64'(a_ram_wdata), 0);
      check("t6_rst_mem_ready", 64'(a_mem_ready), 0);
      check("t6_rst_if_rdata", 64'(a_if_rdata), 0);
      check("t6_rst_mem_rdata", 64'(a_mem_rdata), 0);
      check("t6_rst_if_stall", 64'(a_if_stall), 0);
      tick(); tick();
      rst_n = 1;
      repeat (3) tick();
      sample();
      check("t6_no_stale_ready", 64'(a_mem_ready), 0);
      // MEM_LATENCY=1 fetch completes one cycle after the request
      tick();
      if_req = 1; if_addr = 32'h40;
      q_if.push_back('{ram_f(32'h40), cyc + 2});
      sample();
      check("t7_l1_ready_c0", 64'(b_if_ready), 0);
      check("t7_l1_ram_en_c0", 64'(b_ram_en), 0);
      tick(); sample();
      check("t7_l1_ready_c1", 64'(b_if_ready), 1);
      check("t7_l1_if_rdata", 64'(b_if_rdata), 64'h2408_0005);
      check("t7_l2_not_ready_c1", 64'(a_if_ready), 0);
      tick(); sample();
      tick(); if_req = 0;
      repeat (3) tick();
      check("q_if_empty", 64'(q_if.size()), 0);
      check("q_mem_empty", 64'(q_mem.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
